// File: rtl/afe_pulser_sched_pkg.sv
// Shared definitions for the AFE pulser burst scheduler: FSM encodings and
// default timing constants.
package afe_pulser_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_FIRE = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    localparam int DEF_MIN_PERIOD = 16;
    localparam int DEF_CNT_W      = 16;
    localparam int DEF_PER_W      = 24;

endpackage

// File: rtl/afe_pulser_sched_timer.sv
// Loadable down-counter for trig spacing; tc flags the last cycle of a period
// so the scheduler can decide on the next trig one cycle ahead.
module afe_pulser_sched_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - W'(1);
        end
    end

    assign tc = (cnt_reg == W'(1));

endmodule

// File: rtl/afe_pulser_sched.sv
// Burst scheduler for the AFE pulser: latches a burst config on start and
// issues single-cycle trig pulses at a fixed, clamped period.
module afe_pulser_sched
    import afe_pulser_sched_pkg::*;
#(
    parameter int MIN_PERIOD = DEF_MIN_PERIOD,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int PER_W      = DEF_PER_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             ext_en,
    input  logic             ext_trig,
    input  logic [CNT_W-1:0] n_pulses,
    input  logic [PER_W-1:0] period,
    input  logic [15:0]      width_in,
    input  logic             y0_in,
    output logic             trig,
    output logic [15:0]      width_out,
    output logic             y0_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulse_cnt
);

    state_t           state_reg, state_next;
    logic [1:0]       ext_sync_reg;
    logic             ext_dly_reg;
    logic             ext_rise;
    logic [PER_W-1:0] per_l_reg;
    logic [CNT_W-1:0] n_l_reg;
    logic [15:0]      width_reg;
    logic             y0_reg;
    logic             trig_reg, trig_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             accept;
    logic             burst_last;
    logic             tmr_tc;
    logic [PER_W-1:0] per_clamped;

    // Two-stage synchronizer followed by a rising-edge detector on the synced level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_sync_reg <= '0;
            ext_dly_reg  <= 1'b0;
        end else begin
            ext_sync_reg <= {ext_sync_reg[0], ext_trig};
            ext_dly_reg  <= ext_sync_reg[1];
        end
    end

    assign ext_rise    = ext_sync_reg[1] & ~ext_dly_reg;
    assign accept      = (state_reg == S_IDLE) & start & ~stop;
    assign burst_last  = (n_l_reg != '0) && (cnt_reg == n_l_reg);
    assign per_clamped = (period < PER_W'(MIN_PERIOD)) ? PER_W'(MIN_PERIOD) : period;

    afe_pulser_sched_timer #(
        .W (PER_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state_reg == S_FIRE),
        .load_val (per_l_reg - PER_W'(1)),
        .tc       (tmr_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (stop) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE:  if (start)    state_next = ext_en ? S_ARM : S_FIRE;
                S_ARM:   if (ext_rise) state_next = S_FIRE;
                S_FIRE:  state_next = S_WAIT;
                S_WAIT:  if (tmr_tc)   state_next = burst_last ? S_IDLE : S_FIRE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // trig is registered off the transition into S_FIRE so it lines up with the
    // state change; the pulse count moves with the trig it describes.
    always_comb begin
        trig_next = (state_next == S_FIRE);
        busy_next = (state_next != S_IDLE);
        done_next = (state_reg == S_WAIT) & tmr_tc & burst_last & ~stop;
        cnt_next  = accept ? '0 : cnt_reg;
        if (trig_next) begin
            cnt_next = cnt_next + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_reg <= 1'b0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
            cnt_reg  <= '0;
        end else begin
            trig_reg <= trig_next;
            busy_reg <= busy_next;
            done_reg <= done_next;
            cnt_reg  <= cnt_next;
        end
    end

    // Burst config is frozen for the whole burst; only an accepted start reloads it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_l_reg <= '0;
            n_l_reg   <= '0;
            width_reg <= '0;
            y0_reg    <= 1'b0;
        end else if (accept) begin
            per_l_reg <= per_clamped;
            n_l_reg   <= n_pulses;
            width_reg <= width_in;
            y0_reg    <= y0_in;
        end
    end

    assign trig      = trig_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign pulse_cnt = cnt_reg;
    assign width_out = width_reg;
    assign y0_out    = y0_reg;

endmodule

// File: tb/tb_afe_pulser_sched.sv
// Bench for afe_pulser_sched: directed burst scenarios plus randomized traffic,
// checked every cycle against an event-time model of the scheduler.
module tb_afe_pulser_sched;

    localparam int CNT_W = 16;
    localparam int PER_W = 24;
    localparam int MINP  = 16;
    localparam int HIST  = 20000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             ext_en = 1'b0;
    logic             ext_trig = 1'b0;
    logic [CNT_W-1:0] n_pulses = '0;
    logic [PER_W-1:0] period = '0;
    logic [15:0]      width_in = '0;
    logic             y0_in = 1'b0;
    logic             trig;
    logic [15:0]      width_out;
    logic             y0_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pulse_cnt;

    always #5 clk = ~clk;

    afe_pulser_sched #(
        .MIN_PERIOD (MINP),
        .CNT_W      (CNT_W),
        .PER_W      (PER_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .ext_en    (ext_en),
        .ext_trig  (ext_trig),
        .n_pulses  (n_pulses),
        .period    (period),
        .width_in  (width_in),
        .y0_in     (y0_in),
        .trig      (trig),
        .width_out (width_out),
        .y0_out    (y0_out),
        .busy      (busy),
        .done      (done),
        .pulse_cnt (pulse_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;
    int edge_no = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %0d, expected %0d", tag, edge_no, act, exp);
        end
    endtask

    // Reference model: tracks the absolute edge of the next scheduled event
    typedef enum {M_IDLE, M_ARMED, M_RUN} mmode_t;
    mmode_t      m_mode = M_IDLE;
    int          m_next = 0;
    int          m_per = 0;
    int unsigned m_n = 0;
    int unsigned m_cnt = 0;
    bit          m_busy = 0, m_trig = 0, m_done = 0, m_y0 = 0;
    bit [15:0]   m_width = 0;
    bit          ext_hist [HIST];
    int          trig_log [$];
    int          done_log [$];

    task automatic model_reset();
        m_mode = M_IDLE; m_next = 0; m_per = 0; m_n = 0; m_cnt = 0;
        m_busy = 0; m_trig = 0; m_done = 0; m_y0 = 0; m_width = 0;
    endtask

    task automatic fire();
        m_mode = M_RUN;
        m_trig = 1;
        m_cnt  = (m_cnt + 1) % (1 << CNT_W);
        m_next = edge_no + m_per;
    endtask

    // An ext edge sampled at edge e reaches the FSM decision at edge e+2
    task automatic model_step();
        bit rise;
        rise = (edge_no >= 3) && ext_hist[edge_no-2] && !ext_hist[edge_no-3];
        ext_hist[edge_no] = ext_trig;
        m_trig = 0;
        m_done = 0;
        if (stop) begin
            m_mode = M_IDLE;
            m_busy = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (start) begin
                    m_per   = (int'(period) < MINP) ? MINP : int'(period);
                    m_n     = n_pulses;
                    m_width = width_in;
                    m_y0    = y0_in;
                    m_cnt   = 0;
                    m_busy  = 1;
                    if (ext_en) m_mode = M_ARMED;
                    else        fire();
                end
                M_ARMED: if (rise) fire();
                M_RUN: if (edge_no == m_next) begin
                    if (m_n != 0 && m_cnt == m_n) begin
                        m_mode = M_IDLE;
                        m_busy = 0;
                        m_done = 1;
                    end else begin
                        fire();
                    end
                end
                default: m_mode = M_IDLE;
            endcase
        end
        edge_no++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (trig === 1'b1) trig_log.push_back(edge_no - 1);
        if (done === 1'b1) done_log.push_back(edge_no - 1);
        check("trig", 32'(trig), 32'(m_trig));
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_done));
        check("pulse_cnt", 32'(pulse_cnt), m_cnt);
        check("width_out", 32'(width_out), 32'(m_width));
        check("y0_out", 32'(y0_out), 32'(m_y0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_trig"}, 32'(trig), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_cnt"}, 32'(pulse_cnt), 0);
        check({tag, "_width"}, 32'(width_out), 0);
        check({tag, "_y0"}, 32'(y0_out), 0);
    endtask

    task automatic set_cfg(input int n, input int per, input logic [15:0] w, input logic y0, input logic ee);
        n_pulses = CNT_W'(n);
        period   = PER_W'(per);
        width_in = w;
        y0_in    = y0;
        ext_en   = ee;
    endtask

    task automatic mid_reset();
        stop = 1'b1; start = 1'b0; ext_trig = 1'b0;
        tick();
        stop = 1'b0; start = 1'b1;
        set_cfg(0, 20, 16'h0010, 1'b1, 1'b0);
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("rst_pre_busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_async");
        model_reset();
        @(posedge clk);
        ext_hist[edge_no] = 0;
        ext_hist[edge_no-1] = 0;
        ext_hist[edge_no-2] = 0;
        edge_no++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) tick();
    endtask

    initial begin
        int s;
        int ext_hold;
        int r;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        model_reset();

        // n=3, period=20: trigs at +0,+20,+40 edges, done at +60
        trig_log.delete(); done_log.delete();
        set_cfg(3, 20, 16'h0010, 1'b1, 1'b0);
        s = edge_no; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (70) tick();
        check("t1_ntrig", trig_log.size(), 3);
        for (int i = 0; i < trig_log.size() && i < 3; i++)
            check("t1_trig_at", trig_log[i] - s, 20 * i);
        check("t1_ndone", done_log.size(), 1);
        if (done_log.size() > 0) check("t1_done_at", done_log[0] - s, 60);
        check("t1_cnt", 32'(pulse_cnt), 3);

        // period below the minimum is clamped to 16; period=16 also gives 16
        for (int k = 0; k < 2; k++) begin
            trig_log.delete();
            set_cfg(2, (k == 0) ? 5 : 16, 16'h0022, 1'b0, 1'b0);
            start = 1'b1;
            tick();
            start = 1'b0;
            repeat (40) tick();
            check("t2_ntrig", trig_log.size(), 2);
            if (trig_log.size() == 2) check("t2_spacing", trig_log[1] - trig_log[0], 16);
        end

        // Mid-burst start with a new width is ignored
        trig_log.delete();
        set_cfg(3, 18, 16'h0010, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        set_cfg(1, 40, 16'h0040, 1'b1, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (60) tick();
        check("t5_width", 32'(width_out), 32'h10);
        check("t5_ntrig", trig_log.size(), 3);
        if (trig_log.size() == 3) check("t5_spacing", trig_log[2] - trig_log[1], 18);

        // Ext mode: early edge is ignored, trig lands 2 edges after the sampled edge
        trig_log.delete();
        ext_trig = 1'b1; repeat (3) tick();
        ext_trig = 1'b0; repeat (5) tick();
        set_cfg(1, 20, 16'h0033, 1'b1, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("t4_no_early", trig_log.size(), 0);
        r = edge_no; ext_trig = 1'b1;
        tick();
        repeat (4) tick();
        ext_trig = 1'b0;
        repeat (30) tick();
        check("t4_ntrig", trig_log.size(), 1);
        if (trig_log.size() > 0) check("t4_trig_at", trig_log[0] - r, 2);

        // Continuous burst stopped after its 4th trig
        trig_log.delete(); done_log.delete();
        set_cfg(0, 20, 16'h0044, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200 && trig_log.size() < 4; i++) tick();
        check("t3_reached4", trig_log.size(), 4);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t3_busy_low", 32'(busy), 0);
        repeat (50) tick();
        check("t3_ntrig", trig_log.size(), 4);
        check("t3_ndone", done_log.size(), 0);
        check("t3_cnt", 32'(pulse_cnt), 4);

        // Randomized traffic with config inputs changing every cycle
        ext_hold = 0;
        for (int i = 0; i < 5000; i++) begin
            if (i == 2500) mid_reset();
            start = ($urandom_range(0, 29) == 0);
            stop  = ($urandom_range(0, 199) == 0);
            set_cfg($urandom_range(0, 4), $urandom_range(1, 40), 16'($urandom),
                    1'($urandom), ($urandom_range(0, 2) == 0));
            if (ext_hold > 0) begin
                ext_hold--;
            end else if ($urandom_range(0, 24) == 0) begin
                ext_hold = $urandom_range(1, 4);
            end
            ext_trig = (ext_hold > 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
